// File: rtl/pmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmem_arbiter_pkg : shared types and widths for the pmem arbiter      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pmem_arbiter_pkg;

    localparam int S_ADDR = 32;
    localparam int S_LINE = 256;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_ICACHE = 1'b0,
        ARB_DCACHE = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [S_ADDR-1:0] addr;
        logic [S_LINE-1:0] wdata;
        logic              write;
    } arb_req_t;

endpackage

`default_nettype wire

// File: rtl/pmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmem_arbiter_if : cache-side and memory-side bus of the arbiter      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pmem_arbiter_if;
    import pmem_arbiter_pkg::*;

    logic [S_ADDR-1:0] i_address;
    logic              i_read;
    logic [S_LINE-1:0] i_rdata;
    logic              i_resp;
    logic [S_ADDR-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [S_LINE-1:0] d_wdata;
    logic [S_LINE-1:0] d_rdata;
    logic              d_resp;
    logic [S_ADDR-1:0] pmem_address;
    logic [S_LINE-1:0] pmem_wdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;

    // The arbiter takes the slave view; caches and memory together form the master view.
    modport slave (
        input  i_address, i_read, d_address, d_read, d_write, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_address, pmem_wdata, pmem_read, pmem_write
    );

    modport master (
        output i_address, i_read, d_address, d_read, d_write, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_address, pmem_wdata, pmem_read, pmem_write
    );

endinterface

`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pmem_arbiter : round-robin sharing of the physical-memory line port  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pmem_arbiter
    import pmem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pmem_arbiter_if.slave bus
);

    arb_state_t r_state;
    arb_state_t w_state_next;
    arb_owner_t r_last_grant;
    arb_owner_t w_grant_owner;
    arb_req_t   r_req;
    logic       w_grant;
    logic       w_i_req;
    logic       w_d_req;

    assign bus.i_rdata      = bus.pmem_rdata;
    assign bus.d_rdata      = bus.pmem_rdata;
    assign bus.pmem_address = r_req.addr;
    assign bus.pmem_wdata   = r_req.wdata;

    always_comb begin
        w_state_next   = r_state;
        w_grant        = 1'b0;
        w_grant_owner  = r_last_grant;
        w_i_req        = bus.i_read;
        w_d_req        = bus.d_read | bus.d_write;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.i_resp     = 1'b0;
        bus.d_resp     = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = (r_last_grant == ARB_ICACHE) ? ARB_DCACHE : ARB_ICACHE;
                end else if (w_i_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = ARB_ICACHE;
                end else if (w_d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = ARB_DCACHE;
                end
                if (w_grant) begin
                    w_state_next = (w_grant_owner == ARB_ICACHE) ? ARB_SERVE_I : ARB_SERVE_D;
                end
            end
            ARB_SERVE_I: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.i_resp   = 1'b1;
                    w_state_next = ARB_DONE;
                end
            end
            ARB_SERVE_D: begin
                bus.pmem_read  = ~r_req.write;
                bus.pmem_write = r_req.write;
                if (bus.pmem_resp) begin
                    bus.d_resp   = 1'b1;
                    w_state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                // Bubble lets the served cache drop its request before re-arbitration.
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= ARB_DCACHE;
            r_req        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_last_grant <= w_grant_owner;
                if (w_grant_owner == ARB_ICACHE) begin
                    r_req.addr  <= bus.i_address;
                    r_req.write <= 1'b0;
                end else begin
                    // Read and write together resolve to the writeback.
                    r_req.addr  <= bus.d_address;
                    r_req.wdata <= bus.d_wdata;
                    r_req.write <= bus.d_write;
                end
            end
        end
    end

endmodule

`default_nettype wire
